// File: rtl/bu_ntt_dual.sv
// Dual-mode NTT butterfly (Cooley-Tukey / Gentleman-Sande), 8-stage pipeline mod Q.
// Optional BU_INTT_HALF_EN: scale mode=1 results by 2^-1 mod Q.
module bu_ntt_dual #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned Q     = 8380417
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  input  logic             mode,
  input  logic [WIDTH-1:0] A_In,
  input  logic [WIDTH-1:0] B_In,
  input  logic [WIDTH-1:0] W_In,
  output logic [WIDTH-1:0] A_Out,
  output logic [WIDTH-1:0] B_Out,
  output logic             out_valid
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam logic [WIDTH-1:0] QV = WIDTH'(Q);
  localparam logic [PW-1:0]    QP = PW'(Q);

  // Operands stay below Q < 2^(WIDTH-1), so these never overflow WIDTH bits.
  function automatic logic [WIDTH-1:0] add_mod(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] s;
    s = x + y;
    return (s >= QV) ? s - QV : s;
  endfunction

  function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    return (x >= y) ? x - y : x + QV - y;
  endfunction

`ifdef BU_INTT_HALF_EN
  function automatic logic [WIDTH-1:0] half_mod(input logic [WIDTH-1:0] x);
    return x[0] ? ((x + QV) >> 1) : (x >> 1);
  endfunction
`endif

  logic             r1_v, r1_m;
  logic [WIDTH-1:0] r1_a, r1_b, r1_w;
  logic             r2_v, r2_m;
  logic [WIDTH-1:0] r2_a, r2_b, r2_w;
  logic             r3_v, r3_m;
  logic [WIDTH-1:0] r3_a;
  logic [PW-1:0]    r3_p;
  logic             r4_v, r4_m;
  logic [WIDTH-1:0] r4_a, r4_r;
  logic             r5_v;
`ifdef BU_INTT_HALF_EN
  logic             r5_m;
`endif
  logic [WIDTH-1:0] r5_x, r5_y;
  logic             r6_v, r7_v;
  logic [WIDTH-1:0] r6_x, r6_y, r7_x, r7_y;

  logic [WIDTH-1:0] w_s5_x, w_s5_y;

  // Final butterfly combine: CT adds/subtracts the reduced product, GS passes through.
  always_comb begin
    w_s5_x = r4_a;
    w_s5_y = r4_r;
    if (!r4_m) begin
      w_s5_x = add_mod(r4_a, r4_r);
      w_s5_y = sub_mod(r4_a, r4_r);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_v <= 1'b0; r1_m <= 1'b0; r1_a <= '0; r1_b <= '0; r1_w <= '0;
      r2_v <= 1'b0; r2_m <= 1'b0; r2_a <= '0; r2_b <= '0; r2_w <= '0;
      r3_v <= 1'b0; r3_m <= 1'b0; r3_a <= '0; r3_p <= '0;
      r4_v <= 1'b0; r4_m <= 1'b0; r4_a <= '0; r4_r <= '0;
      r5_v <= 1'b0; r5_x <= '0; r5_y <= '0;
`ifdef BU_INTT_HALF_EN
      r5_m <= 1'b0;
`endif
      r6_v <= 1'b0; r6_x <= '0; r6_y <= '0;
      r7_v <= 1'b0; r7_x <= '0; r7_y <= '0;
      out_valid <= 1'b0; A_Out <= '0; B_Out <= '0;
    end else if (en) begin
      r1_v <= in_valid; r1_m <= mode; r1_a <= A_In; r1_b <= B_In; r1_w <= W_In;

      // GS pre-combine; CT forwards A and B unchanged
      r2_v <= r1_v; r2_m <= r1_m; r2_w <= r1_w;
      r2_a <= r1_m ? add_mod(r1_a, r1_b) : r1_a;
      r2_b <= r1_m ? sub_mod(r1_a, r1_b) : r1_b;

      r3_v <= r2_v; r3_m <= r2_m; r3_a <= r2_a;
      r3_p <= PW'(r2_b) * PW'(r2_w);

      r4_v <= r3_v; r4_m <= r3_m; r4_a <= r3_a;
      r4_r <= WIDTH'(r3_p % QP);

      r5_v <= r4_v; r5_x <= w_s5_x; r5_y <= w_s5_y;
`ifdef BU_INTT_HALF_EN
      r5_m <= r4_m;
      r6_x <= r5_m ? half_mod(r5_x) : r5_x;
      r6_y <= r5_m ? half_mod(r5_y) : r5_y;
`else
      r6_x <= r5_x;
      r6_y <= r5_y;
`endif
      r6_v <= r5_v;

      r7_v <= r6_v; r7_x <= r6_x; r7_y <= r6_y;

      out_valid <= r7_v; A_Out <= r7_x; B_Out <= r7_y;
    end
  end

endmodule

// File: tb/tb_bu_ntt_dual.sv
// Scoreboard bench for bu_ntt_dual: directed vectors, alternating-mode random stream, stall and mid-stream reset.
module tb_bu_ntt_dual;

  localparam int unsigned WIDTH = 32;
  localparam longint      Q     = 8380417;

  logic             clk = 1'b0;
  logic             rst_n, en, in_valid, mode;
  logic [WIDTH-1:0] A_In, B_In, W_In;
  logic [WIDTH-1:0] A_Out, B_Out;
  logic             out_valid;

  bu_ntt_dual #(.WIDTH(WIDTH), .Q(Q)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .mode(mode),
    .A_In(A_In), .B_In(B_In), .W_In(W_In),
    .A_Out(A_Out), .B_Out(B_Out), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint a;
    longint b;
    int     stamp;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   en_cnt  = 0;
  logic tb_en_q = 1'b0;
  logic             last_v = 1'b0;
  logic [WIDTH-1:0] last_a = '0, last_b = '0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic longint half(input longint v);
    return (v % 2 == 0) ? v / 2 : (v + Q) / 2;
  endfunction

  function automatic exp_t model(input logic m, input longint a, input longint b, input longint w);
    exp_t e;
    longint t;
    if (!m) begin
      t   = (b * w) % Q;
      e.a = (a + t) % Q;
      e.b = (a - t + Q) % Q;
    end else begin
      e.a = (a + b) % Q;
      e.b = (((a - b + Q) % Q) * w) % Q;
`ifdef BU_INTT_HALF_EN
      e.a = half(e.a);
      e.b = half(e.b);
`endif
    end
    e.stamp = 0;
    return e;
  endfunction

  // Capture accepted samples into the scoreboard and count enabled edges.
  always @(posedge clk) begin
    exp_t e;
    if (rst_n && en) begin
      if (in_valid) begin
        e = model(mode, longint'(A_In), longint'(B_In), longint'(W_In));
        e.stamp = en_cnt;
        sb.push_back(e);
      end
      en_cnt <= en_cnt + 1;
    end
    tb_en_q <= en && rst_n;
  end

  // Compare outputs mid-cycle; during stalls outputs must hold.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (tb_en_q) begin
        if (out_valid) begin
          if (sb.size() == 0) begin
            check("stale_out_valid", 1, 0);
          end else begin
            e = sb.pop_front();
            check("A_Out", longint'(A_Out), e.a);
            check("B_Out", longint'(B_Out), e.b);
            check("latency", longint'(en_cnt - e.stamp), 8);
          end
        end
      end else begin
        check("hold_valid", longint'(out_valid), longint'(last_v));
        check("hold_A", longint'(A_Out), longint'(last_a));
        check("hold_B", longint'(B_Out), longint'(last_b));
      end
    end
    last_v = out_valid;
    last_a = A_Out;
    last_b = B_Out;
  end

  task automatic drive(input logic v, input logic m, input longint a, input longint b, input longint w);
    @(posedge clk);
    #1;
    en       = 1'b1;
    in_valid = v;
    mode     = m;
    A_In     = WIDTH'(a);
    B_In     = WIDTH'(b);
    W_In     = WIDTH'(w);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 40) begin
      drive(1'b0, 1'b0, 0, 0, 0);
      k++;
    end
    idle(2);
    check("drain_empty", longint'(sb.size()), 0);
  endtask

  function automatic longint rnd();
    return longint'($urandom_range(32'(Q - 1), 0));
  endfunction

  initial begin
    rst_n = 1'b0; en = 1'b0; in_valid = 1'b0; mode = 1'b0;
    A_In = '0; B_In = '0; W_In = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", longint'(out_valid), 0);
    check("reset_A", longint'(A_Out), 0);
    check("reset_B", longint'(B_Out), 0);
    rst_n = 1'b1;

    // Directed vectors, including wrap-around in both modes
    drive(1'b1, 1'b0, 5, 3, 2);
    idle(10);
    drive(1'b1, 1'b1, 5, 3, 2);
    drive(1'b1, 1'b0, Q - 1, 1, 1);
    drive(1'b1, 1'b1, 0, 1, 1);
    drive(1'b1, 1'b0, Q - 1, Q - 1, Q - 1);
    drive(1'b1, 1'b1, 0, Q - 1, Q - 1);
    drain();

    // Alternating modes, back-to-back random samples
    for (int i = 0; i < 64; i++) drive(1'b1, 1'(i % 2), rnd(), rnd(), rnd());
    drain();

    // 10-sample stream with a 3-cycle stall; in_valid held high while stalled
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'(i % 2), rnd(), rnd(), rnd());
      if (i == 4) begin
        for (int s = 0; s < 3; s++) begin
          @(posedge clk);
          #1;
          en = 1'b0; in_valid = 1'b1; mode = 1'b1;
          A_In = WIDTH'(rnd()); B_In = WIDTH'(rnd()); W_In = WIDTH'(rnd());
        end
      end
    end
    drain();

    // Reset with 5 samples in flight
    for (int i = 0; i < 5; i++) drive(1'b1, 1'(i % 2), rnd(), rnd(), rnd());
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midreset_valid", longint'(out_valid), 0);
    check("midreset_A", longint'(A_Out), 0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(12);
    drive(1'b1, 1'b0, 5, 3, 2);
    drive(1'b1, 1'b1, 7, 9, 11);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
